regx_init: RTL and testbench

REGX_INIT -- requirements
Module: regx_init

---
 rtl/regx_init_if.sv | 24 ++
 rtl/regx_init.sv | 143 ++++++++++++++
 tb/tb_regx_init.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regx_init_if.sv
// Command/response handshake bundle for the regx init sequencer.
// master = requester, slave = regx_init.
interface regx_init_if;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [1:0] cmd_op;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdat;
    logic [7:0] cmd_mask;
    logic       rsp_vld;
    logic       rsp_rdy;
    logic [7:0] rsp_dat;
    logic       rsp_err;

    modport master (
        output cmd_vld, cmd_op, cmd_addr, cmd_wdat, cmd_mask, rsp_rdy,
        input  cmd_rdy, rsp_vld, rsp_dat, rsp_err
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_addr, cmd_wdat, cmd_mask, rsp_rdy,
        output cmd_rdy, rsp_vld, rsp_dat, rsp_err
    );
endinterface

// File: rtl/regx_init.sv
// Register-bus init sequencer: write, read, read-modify-write and
// bounded poll commands, one at a time, with registered bus strobes.
module regx_init #(
    parameter logic [7:0] POLL_MAX = 8'd15
) (
    input  logic        clk,
    input  logic        rrst,
    regx_init_if.slave  cmd,
    output logic        regx_r,
    output logic        regx_w,
    output logic [6:0]  regx_addr,
    output logic [7:0]  regx_wdat,
    input  logic [7:0]  regx_rdat
);

    typedef enum logic [2:0] {
        IDLE,
        RADR,
        RDAT,
        WRT,
        RSP
    } state_e;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_RMW = 2'b10;

    state_e     state_q;
    logic [1:0] op_q;
    logic [7:0] wdat_q;
    logic [7:0] mask_q;
    logic [7:0] cnt_q;
    logic       cmd_rdy_q;
    logic       rsp_vld_q;
    logic [7:0] rsp_dat_q;
    logic       rsp_err_q;
    logic       regx_r_q;
    logic       regx_w_q;
    logic [6:0] regx_addr_q;
    logic [7:0] regx_wdat_q;

    // Merge uses the live read data so the write can issue straight from RDAT.
    logic [7:0] rmw_wdat_d;
    logic       poll_hit_d;

    assign rmw_wdat_d = (regx_rdat & ~mask_q) | (wdat_q & mask_q);
    assign poll_hit_d = ((regx_rdat ^ wdat_q) & mask_q) == 8'h00;

    always_ff @(posedge clk) begin
        if (rrst) begin
            state_q     <= IDLE;
            op_q        <= OP_WR;
            wdat_q      <= 8'h00;
            mask_q      <= 8'h00;
            cnt_q       <= 8'h00;
            cmd_rdy_q   <= 1'b1;
            rsp_vld_q   <= 1'b0;
            rsp_dat_q   <= 8'h00;
            rsp_err_q   <= 1'b0;
            regx_r_q    <= 1'b0;
            regx_w_q    <= 1'b0;
            regx_addr_q <= 7'h00;
            regx_wdat_q <= 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd.cmd_vld) begin
                        op_q        <= cmd.cmd_op;
                        wdat_q      <= cmd.cmd_wdat;
                        mask_q      <= cmd.cmd_mask;
                        regx_addr_q <= cmd.cmd_addr;
                        cnt_q       <= 8'h00;
                        rsp_err_q   <= 1'b0;
                        cmd_rdy_q   <= 1'b0;
                        if (cmd.cmd_op == OP_WR) begin
                            state_q     <= WRT;
                            regx_w_q    <= 1'b1;
                            regx_wdat_q <= cmd.cmd_wdat;
                        end else begin
                            state_q  <= RADR;
                            regx_r_q <= 1'b1;
                        end
                    end
                end
                RADR: begin
                    regx_r_q <= 1'b0;
                    state_q  <= RDAT;
                end
                RDAT: begin
                    rsp_dat_q <= regx_rdat;
                    if (op_q == OP_RMW) begin
                        state_q     <= WRT;
                        regx_w_q    <= 1'b1;
                        regx_wdat_q <= rmw_wdat_d;
                    end else if (op_q == OP_RD || poll_hit_d) begin
                        state_q   <= RSP;
                        rsp_vld_q <= 1'b1;
                    end else if (cnt_q < POLL_MAX) begin
                        cnt_q    <= cnt_q + 8'd1;
                        state_q  <= RADR;
                        regx_r_q <= 1'b1;
                    end else begin
                        state_q   <= RSP;
                        rsp_vld_q <= 1'b1;
                        rsp_err_q <= 1'b1;
                    end
                end
                WRT: begin
                    regx_w_q  <= 1'b0;
                    state_q   <= RSP;
                    rsp_vld_q <= 1'b1;
                    if (op_q == OP_WR) begin
                        rsp_dat_q <= wdat_q;
                    end
                end
                RSP: begin
                    if (cmd.rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        cmd_rdy_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cmd_rdy_q <= 1'b1;
                    rsp_vld_q <= 1'b0;
                    regx_r_q  <= 1'b0;
                    regx_w_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_rdy = cmd_rdy_q;
    assign cmd.rsp_vld = rsp_vld_q;
    assign cmd.rsp_dat = rsp_dat_q;
    assign cmd.rsp_err = rsp_err_q;
    assign regx_r      = regx_r_q;
    assign regx_w      = regx_w_q;
    assign regx_addr   = regx_addr_q;
    assign regx_wdat   = regx_wdat_q;

endmodule

// File: tb/tb_regx_init.sv
// Table-driven bench for regx_init with a scoreboard queue and a
// behavioural register responder; plus reset-abort sequences.
module tb_regx_init;

    typedef struct {
        logic [1:0] op;
        logic [6:0] addr;
        logic [7:0] wdat;
        logic [7:0] mask;
        logic [7:0] rd_hit;
        logic [7:0] rd_miss;
        int         hit_at;
        int         hold;
        logic [7:0] e_dat;
        logic       e_err;
        int         e_lat;
        int         e_nr;
        int         e_nw;
        int         e_wat;
        logic [7:0] e_wdat;
    } vec_t;

    logic       clk;
    logic       rrst;
    logic       regx_r;
    logic       regx_w;
    logic [6:0] regx_addr;
    logic [7:0] regx_wdat;
    logic [7:0] regx_rdat;

    int errors;
    int checks;

    vec_t sb[$];
    vec_t tbl[11];

    regx_init_if bus ();

    regx_init #(.POLL_MAX(8'd15)) dut (
        .clk       (clk),
        .rrst      (rrst),
        .cmd       (bus),
        .regx_r    (regx_r),
        .regx_w    (regx_w),
        .regx_addr (regx_addr),
        .regx_wdat (regx_wdat),
        .regx_rdat (regx_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] op, input logic [6:0] addr,
        input logic [7:0] wdat, input logic [7:0] mask,
        input logic [7:0] rd_hit, input logic [7:0] rd_miss,
        input int hit_at, input int hold,
        input logic [7:0] e_dat, input logic e_err, input int e_lat,
        input int e_nr, input int e_nw, input int e_wat,
        input logic [7:0] e_wdat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdat = wdat; v.mask = mask;
        v.rd_hit = rd_hit; v.rd_miss = rd_miss;
        v.hit_at = hit_at; v.hold = hold;
        v.e_dat = e_dat; v.e_err = e_err; v.e_lat = e_lat;
        v.e_nr = e_nr; v.e_nw = e_nw; v.e_wat = e_wat;
        v.e_wdat = e_wdat;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int k, nr, nw, wat, badaddr, badrw, busy, unstable;
        logic seen;
        logic [7:0] dat0, wd0;
        logic err0;
        nr = 0; nw = 0; wat = 0; badaddr = 0; badrw = 0;
        busy = 0; unstable = 0; seen = 1'b0;
        @(negedge clk);
        chk({tag, ".cmd_rdy"}, {31'b0, bus.cmd_rdy}, 32'd1);
        bus.cmd_vld  = 1'b1;
        bus.cmd_op   = v.op;
        bus.cmd_addr = v.addr;
        bus.cmd_wdat = v.wdat;
        bus.cmd_mask = v.mask;
        bus.rsp_rdy  = 1'b0;
        regx_rdat    = v.rd_miss;
        sb.push_back(v);
        @(posedge clk);
        for (k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // junk command held valid while busy must be ignored
                bus.cmd_op   = ~v.op;
                bus.cmd_addr = ~v.addr;
                bus.cmd_wdat = ~v.wdat;
                bus.cmd_mask = ~v.mask;
            end
            if (regx_r && regx_w) badrw++;
            if ((regx_r || regx_w) && regx_addr != v.addr) badaddr++;
            if (bus.cmd_rdy) busy++;
            if (regx_r) begin
                nr++;
                regx_rdat = (v.hit_at != 0 && nr >= v.hit_at) ?
                            v.rd_hit : v.rd_miss;
            end
            if (regx_w) begin
                nw++;
                wat = k;
                if (regx_wdat !== v.e_wdat) badrw++;
            end
            if (bus.rsp_vld) begin
                seen = 1'b1;
                break;
            end
        end
        bus.cmd_vld = 1'b0;
        e = sb.pop_front();
        chk({tag, ".rsp_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, ".lat"}, k, e.e_lat);
        chk({tag, ".rsp_dat"}, {24'b0, bus.rsp_dat}, {24'b0, e.e_dat});
        chk({tag, ".rsp_err"}, {31'b0, bus.rsp_err}, {31'b0, e.e_err});
        chk({tag, ".n_rd"}, nr, e.e_nr);
        chk({tag, ".n_wr"}, nw, e.e_nw);
        if (e.e_nw != 0) chk({tag, ".w_at"}, wat, e.e_wat);
        chk({tag, ".addr_bad"}, badaddr, 0);
        chk({tag, ".strobe_bad"}, badrw, 0);
        chk({tag, ".busy_rdy"}, busy, 0);
        dat0 = bus.rsp_dat;
        err0 = bus.rsp_err;
        wd0  = regx_wdat;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!bus.rsp_vld || bus.cmd_rdy || bus.rsp_dat !== dat0 ||
                bus.rsp_err !== err0 || regx_wdat !== wd0 ||
                regx_r || regx_w)
                unstable++;
        end
        if (v.hold != 0) chk({tag, ".hold"}, unstable, 0);
        bus.rsp_rdy = 1'b1;
        @(negedge clk);
        bus.rsp_rdy = 1'b0;
        chk({tag, ".done"},
            {28'b0, bus.rsp_vld, bus.cmd_rdy, regx_r, regx_w},
            32'b0100);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".cmd_rdy"}, {31'b0, bus.cmd_rdy}, 32'd1);
        chk({tag, ".rsp_vld"}, {31'b0, bus.rsp_vld}, 32'd0);
        chk({tag, ".rsp_err"}, {31'b0, bus.rsp_err}, 32'd0);
        chk({tag, ".rsp_dat"}, {24'b0, bus.rsp_dat}, 32'd0);
        chk({tag, ".strobes"}, {30'b0, regx_r, regx_w}, 32'd0);
        chk({tag, ".regx_addr"}, {25'b0, regx_addr}, 32'd0);
        chk({tag, ".regx_wdat"}, {24'b0, regx_wdat}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int late;
        errors = 0;
        checks = 0;
        //        op     addr   wdat   mask   hit    miss  at hold dat   err lat nr nw wat ewdat
        tbl[0]  = mk(2'd0, 7'h04, 8'h5a, 8'h00, 8'h00, 8'h00, 0, 2, 8'h5a, 0,  2, 0, 1, 1, 8'h5a);
        tbl[1]  = mk(2'd1, 7'h13, 8'h00, 8'h00, 8'hc3, 8'h00, 1, 5, 8'hc3, 0,  3, 1, 0, 0, 8'h00);
        tbl[2]  = mk(2'd2, 7'h17, 8'h05, 8'h0f, 8'hf0, 8'h00, 1, 1, 8'hf0, 0,  4, 1, 1, 3, 8'hf5);
        tbl[3]  = mk(2'd3, 7'h1f, 8'h01, 8'h01, 8'h01, 8'h00, 3, 0, 8'h01, 0,  7, 3, 0, 0, 8'h00);
        tbl[4]  = mk(2'd3, 7'h1f, 8'h01, 8'h01, 8'h01, 8'hfe, 0, 2, 8'hfe, 1, 33,16, 0, 0, 8'h00);
        tbl[5]  = mk(2'd1, 7'h7f, 8'h00, 8'h00, 8'h5a, 8'h00, 1, 0, 8'h5a, 0,  3, 1, 0, 0, 8'h00);
        tbl[6]  = mk(2'd3, 7'h20, 8'hab, 8'h00, 8'h00, 8'h12, 0, 0, 8'h12, 0,  3, 1, 0, 0, 8'h00);
        tbl[7]  = mk(2'd2, 7'h05, 8'ha5, 8'hff, 8'h3c, 8'h00, 1, 0, 8'h3c, 0,  4, 1, 1, 3, 8'ha5);
        tbl[8]  = mk(2'd3, 7'h40, 8'h80, 8'hc0, 8'h9f, 8'h40,16, 0, 8'h9f, 0, 33,16, 0, 0, 8'h00);
        tbl[9]  = mk(2'd0, 7'h00, 8'hff, 8'h00, 8'h00, 8'h00, 0, 1, 8'hff, 0,  2, 0, 1, 1, 8'hff);
        tbl[10] = mk(2'd2, 7'h33, 8'h11, 8'h00, 8'h77, 8'h00, 1, 0, 8'h77, 0,  4, 1, 1, 3, 8'h77);

        rrst = 1'b1;
        bus.cmd_vld  = 1'b0;
        bus.cmd_op   = 2'd0;
        bus.cmd_addr = 7'h00;
        bus.cmd_wdat = 8'h00;
        bus.cmd_mask = 8'h00;
        bus.rsp_rdy  = 1'b0;
        regx_rdat    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        rrst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // abort an RMW while it sits in RDAT
        @(negedge clk);
        bus.cmd_vld  = 1'b1;
        bus.cmd_op   = 2'd2;
        bus.cmd_addr = 7'h17;
        bus.cmd_wdat = 8'h05;
        bus.cmd_mask = 8'h0f;
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        chk("abort.radr", {31'b0, regx_r}, 32'd1);
        regx_rdat = 8'hf0;
        @(negedge clk);
        rrst = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        rrst = 1'b0;
        late = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (regx_w || regx_r || bus.rsp_vld) late++;
        end
        chk("abort.quiet", late, 0);

        run_vec(tbl[0], "post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
